axi_read_slave_mem: RTL and testbench
=====================================

Name: axi_read_slave_mem

Overview:
- AXI4 read-only memory slave; sits directly downstream of the read interconnect on an S0/S1 slave port.
- Accepts one AR request at a time and returns ARLEN+1 beats from an internal word-organised RAM.
- Supports FIXED, INCR and WRAP bursts.
- A side-band write port preloads the RAM for system bring-up and test.

Parameters:
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 32, RDATA width; power of two, at least 8
- ARLEN_WIDTH, 4, burst length field width (1–16 beats)
- ARSIZE_WIDTH, 3, size field width
- ARBURST_WIDTH, 2, burst type field width
- RRESP_WIDTH, 2, response width
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0
- MEM_DEPTH, 1024, RAM depth in DATA_WIDTH words

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_ARADDR  in  ADDR_WIDTH  read address
- S_ARLEN  in  ARLEN_WIDTH  beats minus 1
- S_ARSIZE  in  ARSIZE_WIDTH  bytes per beat = 2^ARSIZE
- S_ARBURST  in  ARBURST_WIDTH  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- S_ARVALID  in  1  address valid
- S_ARREADY  out  1  address ready
- S_RDATA  out  DATA_WIDTH  read data
- S_RRESP  out  RRESP_WIDTH  00 OKAY, 10 SLVERR
- S_RLAST  out  1  last beat
- S_RVALID  out  1  data valid
- S_RREADY  in  1  data ready
- mem_we  in  1  preload write enable
- mem_waddr  in  clog2(MEM_DEPTH)  preload word index
- mem_wdata  in  DATA_WIDTH  preload data

Behaviour:
- Reset is asynchronous on ARESETN low.
  - Outputs during reset: ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=00; FSM goes to IDLE.
  - RAM contents are not reset.
  - ARREADY rises at the first ACLK edge after ARESETN is released.
- FSM states:
  - IDLE: ARREADY=1.
  - On ARVALID&&ARREADY at edge T: latch addr/len/size/burst, beat counter=0, ARREADY=0, go to BURST.
  - BURST: first beat appears registered at edge T+1 (RVALID=1 in cycle after handshake).
- Beat advance:
  - On RVALID&&RREADY with not RLAST: the next beat is registered at the same edge and RVALID stays 1, giving one beat per cycle.
  - While RVALID && !RREADY: RDATA, RRESP and RLAST are held stable.
  - RLAST=1 exactly on beat ARLEN.
  - When the last beat is accepted: RVALID=0, RLAST=0, ARREADY=1 at the same edge, go to IDLE. There is one idle cycle between bursts.
- Next-address rules (step = 1<<size):
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: boundary = (len+1)*step; next = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The full word is returned for narrow sizes.
- Per-beat SLVERR (RDATA=0) when addr < BASE_ADDR or index >= MEM_DEPTH.
- Whole-burst SLVERR (all beats RDATA=0, RRESP=10) when any of these holds:
  - burst type is 11,
  - size exceeds log2(DATA_WIDTH/8),
  - WRAP with len not in {1,3,7,15},
  - WRAP with an unaligned address.
- Error bursts still deliver exactly ARLEN+1 beats with correct RLAST.
- RAM read is synchronous.
- Preload: mem_we writes at the edge.
  - Write and read to the same word in the same cycle returns the old data.
  - Preload must not be used while a burst is active; behaviour in that case is old-data read, no error.
- ARVALID asserted in BURST is ignored (ARREADY=0) until the current burst completes.
- Reset mid-burst: RVALID drops immediately and the burst is abandoned; no pending beats remain after reset.

Decomposition:
- Shared package axi_pkg holds:
  - BURST_FIXED/INCR/WRAP/RSVD constants,
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants,
  - a function computing next burst address.
- One natural sub-module: axi_burst_addr_gen (combinational next-address and WRAP-legality check). It is reusable by a future write-slave.

Test Plan:
- Preload words 0..15 with value=index. AR INCR addr 0x0, len 3, size 2 → 4 beats 0,1,2,3, RLAST on beat 3, RRESP=00, first RVALID one cycle after AR handshake.
- WRAP addr 0x8, len 3, size 2 → data 2,3,0,1, RLAST on 4th beat.
- FIXED addr 0x14, len 2 → 5,5,5.
- INCR addr 0xFF8, len 3 (MEM_DEPTH 1024) → beats OKAY data 1022, 1023, then SLVERR with RDATA=0 on the last two beats; RLAST on beat 3.
- Backpressure: RREADY toggled 1,0,0,1,... → RDATA/RLAST stable while stalled, no beat lost or duplicated; ARVALID held during burst not accepted until one cycle after last beat.
- Reset mid-burst: assert ARESETN=0 during beat 2 of a len-7 burst → RVALID=0 asynchronously, ARREADY=0. After release, ARREADY=1 on the first edge and a new burst returns correct data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst-type and response codes, the read FSM state
// type, and the next-beat address computation used by the burst generators.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } rd_state_e;

   // Address of the beat following 'addr'. Computed at 64 bits so callers of
   // any address width can zero-extend in and truncate out.
   function automatic logic [63:0] axi_next_addr(
      input logic [63:0] addr,
      input logic [7:0]  len,
      input logic [2:0]  size,
      input logic [1:0]  burst
   );
      logic [63:0] step;
      logic [63:0] mask;
      logic [63:0] result;
      step = 64'd1 << size;
      mask = ((64'(len) + 64'd1) * step) - 64'd1;
      case (burst)
         BURST_INCR: result = addr + step;
         BURST_WRAP: result = (addr & ~mask) | ((addr + step) & mask);
         default:    result = addr;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address step.
//   addr/len/size/burst : current beat address and the burst's AxLEN/AxSIZE/AxBURST
//   next_addr           : address of the following beat
//   wrap_ok             : 0 only for an illegal WRAP (len not 1/3/7/15, or
//                         start address not aligned to the beat size)
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned ARLEN_WIDTH   = 4,
   parameter int unsigned ARSIZE_WIDTH  = 3,
   parameter int unsigned ARBURST_WIDTH = 2
) (
   input  logic [ADDR_WIDTH-1:0]    addr,
   input  logic [ARLEN_WIDTH-1:0]   len,
   input  logic [ARSIZE_WIDTH-1:0]  size,
   input  logic [ARBURST_WIDTH-1:0] burst,
   output logic [ADDR_WIDTH-1:0]    next_addr,
   output logic                     wrap_ok
);

   logic [7:0]  len8;
   logic [63:0] step;
   logic        len_ok;
   logic        aligned;

   assign len8      = 8'(len);
   assign step      = 64'd1 << 3'(size);
   assign next_addr = ADDR_WIDTH'(axi_next_addr(64'(addr), len8, 3'(size), 2'(burst)));

   assign len_ok  = (len8 == 8'd1) || (len8 == 8'd3) || (len8 == 8'd7) || (len8 == 8'd15);
   assign aligned = ((64'(addr) & (step - 64'd1)) == 64'd0);
   assign wrap_ok = (2'(burst) != BURST_WRAP) || (len_ok && aligned);

endmodule

// File: rtl/axi_read_slave_mem.sv
// AXI4 read-only memory slave. One AR at a time; returns ARLEN+1 beats
// (FIXED/INCR/WRAP) from a word-organised synchronous RAM, which is
// preloaded through a side-band write port.
//   ACLK, ARESETN           : clock, asynchronous active-low reset
//   S_AR*                   : read address channel
//   S_R*                    : read data channel
//   mem_we/waddr/wdata      : RAM preload port (word indexed)
module axi_read_slave_mem
   import axi_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH    = 32,
   parameter int unsigned          DATA_WIDTH    = 32,
   parameter int unsigned          ARLEN_WIDTH   = 4,
   parameter int unsigned          ARSIZE_WIDTH  = 3,
   parameter int unsigned          ARBURST_WIDTH = 2,
   parameter int unsigned          RRESP_WIDTH   = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned          MEM_DEPTH     = 1024
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [ADDR_WIDTH-1:0]        S_ARADDR,
   input  logic [ARLEN_WIDTH-1:0]       S_ARLEN,
   input  logic [ARSIZE_WIDTH-1:0]      S_ARSIZE,
   input  logic [ARBURST_WIDTH-1:0]     S_ARBURST,
   input  logic                         S_ARVALID,
   output logic                         S_ARREADY,
   output logic [DATA_WIDTH-1:0]        S_RDATA,
   output logic [RRESP_WIDTH-1:0]       S_RRESP,
   output logic                         S_RLAST,
   output logic                         S_RVALID,
   input  logic                         S_RREADY,
   input  logic                         mem_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
   input  logic [DATA_WIDTH-1:0]        mem_wdata
);

   localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
   localparam logic [ARSIZE_WIDTH-1:0] MAX_SIZE    = ARSIZE_WIDTH'(BYTE_SHIFT);
   localparam logic [ADDR_WIDTH-1:0]   DEPTH_WORDS = ADDR_WIDTH'(MEM_DEPTH);

   rd_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [ARLEN_WIDTH-1:0]   len_q;
   logic [ARSIZE_WIDTH-1:0]  size_q;
   logic [ARBURST_WIDTH-1:0] burst_q;
   logic [ARLEN_WIDTH-1:0]   cnt_q;
   logic                     arready_q;
   logic                     rvalid_q;
   logic                     rlast_q;
   logic [RRESP_WIDTH-1:0]   rresp_q;
   logic                     beat_err_q;
   logic [DATA_WIDTH-1:0]    ram_q;

   logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0]    next_addr;
   logic                     wrap_ok;
   logic [ADDR_WIDTH-1:0]    word_off;
   logic [IDX_W-1:0]         ram_idx;
   logic                     beat_oob;
   logic                     burst_err;
   logic                     beat_err;
   logic                     ar_fire;
   logic                     load;
   logic                     done;

   axi_burst_addr_gen #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .ARLEN_WIDTH   (ARLEN_WIDTH),
      .ARSIZE_WIDTH  (ARSIZE_WIDTH),
      .ARBURST_WIDTH (ARBURST_WIDTH)
   ) u_addr_gen (
      .addr      (addr_q),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr),
      .wrap_ok   (wrap_ok)
   );

   assign word_off = (addr_q - BASE_ADDR) >> BYTE_SHIFT;
   assign ram_idx  = word_off[IDX_W-1:0];
   assign beat_oob = (addr_q < BASE_ADDR) || (word_off >= DEPTH_WORDS);

   // Legality is evaluated on the live beat address rather than latched at
   // AR time: WRAP addresses stay size-aligned and len/size/burst never
   // change within a burst, so the verdict is the same for every beat.
   assign burst_err = (burst_q == ARBURST_WIDTH'(BURST_RSVD)) || (size_q > MAX_SIZE) || !wrap_ok;
   assign beat_err  = burst_err || beat_oob;

   assign ar_fire = S_ARVALID && arready_q;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ar_fire) state_d = ST_BURST;
         end
         ST_BURST: begin
            // Fetch the first beat right after the handshake, then one per
            // accepted non-last beat.
            load = !rvalid_q || (S_RREADY && !rlast_q);
            if (rvalid_q && S_RREADY && rlast_q) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         cnt_q      <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rresp_q    <= '0;
         beat_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ar_fire) begin
            addr_q    <= S_ARADDR;
            len_q     <= S_ARLEN;
            size_q    <= S_ARSIZE;
            burst_q   <= S_ARBURST;
            cnt_q     <= '0;
            arready_q <= 1'b0;
         end else if ((state_q == ST_IDLE) || done) begin
            arready_q <= 1'b1;
         end
         if (load) begin
            addr_q     <= next_addr;
            cnt_q      <= cnt_q + 1'b1;
            rvalid_q   <= 1'b1;
            rlast_q    <= (cnt_q == len_q);
            rresp_q    <= beat_err ? RRESP_WIDTH'(RESP_SLVERR) : RRESP_WIDTH'(RESP_OKAY);
            beat_err_q <= beat_err;
         end else if (done) begin
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= '0;
            beat_err_q <= 1'b0;
         end
      end
   end

   // RAM array and its read register carry no reset; S_RDATA is gated so it
   // reads zero whenever no valid OKAY beat is presented.
   always_ff @(posedge ACLK) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (load)   ram_q <= mem[ram_idx];
   end

   assign S_ARREADY = arready_q;
   assign S_RVALID  = rvalid_q;
   assign S_RLAST   = rlast_q;
   assign S_RRESP   = rresp_q;
   assign S_RDATA   = (rvalid_q && !beat_err_q) ? ram_q : '0;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
module tb_axi_read_slave_mem;

   localparam int unsigned DEPTH = 1024;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] S_ARADDR;
   logic [3:0]  S_ARLEN;
   logic [2:0]  S_ARSIZE;
   logic [1:0]  S_ARBURST;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RLAST;
   logic        S_RVALID;
   logic        S_RREADY;
   logic        mem_we;
   logic [9:0]  mem_waddr;
   logic [31:0] mem_wdata;

   always #5 ACLK = ~ACLK;

   axi_read_slave_mem #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .ARLEN_WIDTH   (4),
      .ARSIZE_WIDTH  (3),
      .ARBURST_WIDTH (2),
      .RRESP_WIDTH   (2),
      .BASE_ADDR     (32'h0000_0000),
      .MEM_DEPTH     (DEPTH)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .S_ARADDR  (S_ARADDR),
      .S_ARLEN   (S_ARLEN),
      .S_ARSIZE  (S_ARSIZE),
      .S_ARBURST (S_ARBURST),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RLAST   (S_RLAST),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] model_mem [DEPTH];
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;
   int unsigned last_acc_cyc = 0;
   bit          have_last = 1'b0;
   int          rready_mode = 0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: expected beats straight from the burst rules.
   task automatic push_expected(input int unsigned addr, input int unsigned len,
                                input int unsigned size, input int unsigned burst);
      int unsigned step, bnd, a, wb;
      bit berr, oob;
      beat_t b;
      step = 1 << size;
      bnd  = (len + 1) * step;
      berr = (burst == 3) || (size > 2) ||
             ((burst == 2) && (!(len == 1 || len == 3 || len == 7 || len == 15) || (addr % step) != 0));
      a = addr;
      for (int unsigned i = 0; i <= len; i++) begin
         oob    = (a / 4) >= DEPTH;
         b.last = (i == len);
         if (berr || oob) begin
            b.data = '0;
            b.resp = 2'b10;
         end else begin
            b.data = model_mem[a / 4];
            b.resp = 2'b00;
         end
         exp_q.push_back(b);
         if (burst == 1) a = a + step;
         else if (burst == 2) begin
            wb = a - (a % bnd);
            a  = wb + ((a - wb + step) % bnd);
         end
      end
   endtask

   // RREADY: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating.
   initial begin
      int ph;
      ph = 0;
      S_RREADY = 1'b0;
      forever begin
         @(posedge ACLK);
         #1;
         case (rready_mode)
            0:       S_RREADY = 1'b1;
            1:       S_RREADY = 1'($urandom_range(0, 1));
            default: S_RREADY = (ph % 3 == 0);
         endcase
         ph++;
      end
   end

   // Monitor: pops and compares on every accepted beat, and checks hold
   // stability while stalled.
   initial begin
      bit    stalled;
      beat_t prev, exp;
      stalled = 1'b0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled)
            check({S_RVALID, S_RDATA, S_RRESP, S_RLAST} == {1'b1, prev}, "hold_stable",
                  64'({S_RVALID, S_RDATA, S_RRESP, S_RLAST}), 64'({1'b1, prev}));
         stalled = 1'b0;
         if (S_RVALID) begin
            if (S_RREADY) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_beat", 64'(S_RDATA), 64'(0));
               end else begin
                  exp = exp_q.pop_front();
                  check({S_RDATA, S_RRESP, S_RLAST} == exp, "beat",
                        64'({S_RDATA, S_RRESP, S_RLAST}), 64'(exp));
               end
               if (S_RLAST) begin
                  last_acc_cyc = cyc;
                  have_last    = 1'b1;
               end
            end else begin
               stalled = 1'b1;
               prev    = {S_RDATA, S_RRESP, S_RLAST};
            end
         end
      end
   end

   task automatic issue_ar(input int unsigned addr, input int unsigned len, input int unsigned size,
                           input int unsigned burst, input bit expect_gap);
      int n;
      bit got;
      @(posedge ACLK);
      #1;
      S_ARADDR  = addr;
      S_ARLEN   = 4'(len);
      S_ARSIZE  = 3'(size);
      S_ARBURST = 2'(burst);
      S_ARVALID = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 300) begin
         @(negedge ACLK);
         if (S_ARREADY) got = 1'b1;
         else n++;
      end
      if (!got) begin
         check(1'b0, "ar_timeout", 64'(0), 64'(1));
         S_ARVALID = 1'b0;
         return;
      end
      if (expect_gap)
         check(have_last && (cyc == last_acc_cyc + 1), "ar_gap", 64'(cyc), 64'(last_acc_cyc + 1));
      push_expected(addr, len, size, burst);
      @(posedge ACLK);
      #1 S_ARVALID = 1'b0;
      @(negedge ACLK);
      check(S_RVALID == 1'b0, "rvalid_not_early", 64'(S_RVALID), 64'(0));
      @(negedge ACLK);
      check(S_RVALID == 1'b1, "first_rvalid", 64'(S_RVALID), 64'(1));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || S_RVALID) && n < 2000) begin
         @(negedge ACLK);
         n++;
      end
      check(exp_q.size() == 0 && !S_RVALID, "drain", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned a, l, s, b;
      ARESETN = 1'b0;
      S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check({S_ARREADY, S_RVALID, S_RLAST, S_RDATA, S_RRESP} == '0, "reset_outputs",
            64'({S_ARREADY, S_RVALID, S_RLAST, S_RDATA, S_RRESP}), 64'(0));
      #2 ARESETN = 1'b1;
      #1 check(S_ARREADY == 1'b0, "arready_before_edge", 64'(S_ARREADY), 64'(0));
      @(posedge ACLK);
      #1 check(S_ARREADY == 1'b1, "arready_first_edge", 64'(S_ARREADY), 64'(1));

      for (int unsigned i = 0; i < DEPTH; i++) begin
         @(posedge ACLK);
         #1;
         mem_we    = 1'b1;
         mem_waddr = 10'(i);
         mem_wdata = (i < 16 || i >= 1022) ? i : $urandom;
         model_mem[i] = mem_wdata;
      end
      @(posedge ACLK);
      #1 mem_we = 1'b0;

      rready_mode = 0;
      issue_ar(32'h0, 3, 2, 1, 1'b0);   wait_idle();
      issue_ar(32'h8, 3, 2, 2, 1'b0);   wait_idle();
      issue_ar(32'h14, 2, 2, 0, 1'b0);  wait_idle();
      issue_ar(32'hFF8, 3, 2, 1, 1'b0); wait_idle();

      // Backpressure plus an AR held valid across the active burst.
      rready_mode = 2;
      issue_ar(32'h0, 7, 2, 1, 1'b0);
      issue_ar(32'h10, 3, 2, 1, 1'b1);
      wait_idle();
      rready_mode = 0;

      // Whole-burst error cases.
      issue_ar(32'h0, 3, 2, 3, 1'b0); wait_idle();
      issue_ar(32'h0, 1, 3, 1, 1'b0); wait_idle();
      issue_ar(32'h0, 2, 2, 2, 1'b0); wait_idle();
      issue_ar(32'h2, 3, 2, 2, 1'b0); wait_idle();

      // Reset while beat 2 of a len-7 burst is presented.
      issue_ar(32'h0, 7, 2, 1, 1'b0);
      @(negedge ACLK);
      @(negedge ACLK);
      #1 ARESETN = 1'b0;
      exp_q.delete();
      #1 check({S_RVALID, S_ARREADY} == 2'b00, "reset_midburst",
               64'({S_RVALID, S_ARREADY}), 64'(0));
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      #2 ARESETN = 1'b1;
      @(posedge ACLK);
      #1 check(S_ARREADY == 1'b1, "arready_after_reset", 64'(S_ARREADY), 64'(1));
      issue_ar(32'h8, 3, 2, 1, 1'b0); wait_idle();

      rready_mode = 1;
      for (int k = 0; k < 40; k++) begin
         b = $urandom_range(0, 3);
         s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         l = $urandom_range(0, 15);
         a = $urandom_range(0, 32'h1080);
         if ($urandom_range(0, 7) != 0) a = a & ~((1 << s) - 1);
         issue_ar(a, l, s, b, 1'b0);
         wait_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
